// File: rtl/sd_dma_byte_sink_pkg.sv
// ---------------------------------------------------------------------------
// sd_dma_byte_sink_pkg
//   Shared SD controller definitions: controller register map, MMC/SD command
//   and response codes, sector size, byte-lane ordering, and the types used by
//   the DMA byte sink (FIFO word layout, unpacker state).
//   Also provides first_lane(), which picks the next enabled byte lane.
// ---------------------------------------------------------------------------
package sd_dma_byte_sink_pkg;

  // SD controller register map (byte offsets)
  localparam logic [7:0] SDC_ADDR_ARGUMENT = 8'h00;
  localparam logic [7:0] SDC_ADDR_COMMAND  = 8'h04;
  localparam logic [7:0] SDC_ADDR_STATUS   = 8'h08;
  localparam logic [7:0] SDC_ADDR_RESP0    = 8'h0C;
  localparam logic [7:0] SDC_ADDR_CTRL     = 8'h1C;
  localparam logic [7:0] SDC_ADDR_TIMEOUT  = 8'h20;
  localparam logic [7:0] SDC_ADDR_BLKSIZE  = 8'h44;
  localparam logic [7:0] SDC_ADDR_BLKCNT   = 8'h48;
  localparam logic [7:0] SDC_ADDR_DMA_ADDR = 8'h60;

  // MMC/SD command indices
  localparam logic [5:0] SD_CMD_GO_IDLE_STATE     = 6'd0;
  localparam logic [5:0] SD_CMD_SEND_IF_COND     = 6'd8;
  localparam logic [5:0] SD_CMD_STOP_TRANSMISSION = 6'd12;
  localparam logic [5:0] SD_CMD_READ_SINGLE_BLOCK = 6'd17;
  localparam logic [5:0] SD_CMD_READ_MULT_BLOCK   = 6'd18;
  localparam logic [5:0] SD_ACMD_SD_SEND_OP_COND  = 6'd41;
  localparam logic [5:0] SD_CMD_APP_CMD           = 6'd55;

  // Response formats
  typedef enum logic [2:0] {
    SD_RSP_NONE = 3'd0,
    SD_RSP_R1   = 3'd1,
    SD_RSP_R1B  = 3'd2,
    SD_RSP_R2   = 3'd3,
    SD_RSP_R3   = 3'd4,
    SD_RSP_R7   = 3'd5
  } sd_rsp_e;

  localparam int SD_SECTOR_BYTES = 512;

  // Byte-lane order of a 32-bit DMA word on the output stream
  typedef enum logic {
    LANE_MSB_FIRST = 1'b0,   // dat[31:24] first, SD wire order
    LANE_LSB_FIRST = 1'b1    // dat[7:0] first
  } lane_order_e;

  typedef enum logic {
    UNPK_EMPTY = 1'b0,
    UNPK_EMIT  = 1'b1
  } unpk_state_e;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] dat;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

  // Index of the first enabled lane in emission order. Callers only use the
  // result when mask is non-zero.
  function automatic logic [1:0] first_lane(input logic [3:0] mask,
                                            input lane_order_e order);
    logic [1:0] lane;
    lane = 2'd0;
    if (order == LANE_MSB_FIRST) begin
      if      (mask[3]) lane = 2'd3;
      else if (mask[2]) lane = 2'd2;
      else if (mask[1]) lane = 2'd1;
      else              lane = 2'd0;
    end else begin
      if      (mask[0]) lane = 2'd0;
      else if (mask[1]) lane = 2'd1;
      else if (mask[2]) lane = 2'd2;
      else              lane = 2'd3;
    end
    return lane;
  endfunction

endpackage

// File: rtl/sd_dma_byte_sink_if.sv
// ---------------------------------------------------------------------------
// sd_dma_byte_sink_if
//   Wishbone classic bus between the SD controller DMA master and the byte
//   sink slave.
//   master: drives adr/dat_i/sel/we/cyc/stb, receives ack_o/dat_o
//   slave : receives adr/dat_i/sel/we/cyc/stb, drives ack_o/dat_o
// ---------------------------------------------------------------------------
interface sd_dma_byte_sink_if;
  logic [31:0] dma_wb_adr_i;
  logic [31:0] dma_wb_dat_i;
  logic [3:0]  dma_wb_sel_i;
  logic        dma_wb_we_i;
  logic        dma_wb_cyc_i;
  logic        dma_wb_stb_i;
  logic        dma_wb_ack_o;
  logic [31:0] dma_wb_dat_o;

  modport master (
    output dma_wb_adr_i, dma_wb_dat_i, dma_wb_sel_i, dma_wb_we_i,
           dma_wb_cyc_i, dma_wb_stb_i,
    input  dma_wb_ack_o, dma_wb_dat_o
  );

  modport slave (
    input  dma_wb_adr_i, dma_wb_dat_i, dma_wb_sel_i, dma_wb_we_i,
           dma_wb_cyc_i, dma_wb_stb_i,
    output dma_wb_ack_o, dma_wb_dat_o
  );
endinterface

// File: rtl/sd_dma_byte_sink_word_fifo.sv
// ---------------------------------------------------------------------------
// sd_word_fifo
//   Synchronous single-clock FIFO with show-ahead head output.
//   Ports: clk, rst_n (sync, active-low), clear (sync discard of contents),
//          push/wdata, pop/rdata (rdata is the current head),
//          full, empty, count (number of stored words).
//   Push while full and pop while empty are ignored. DEPTH must be a power
//   of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sd_word_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sd_dma_byte_sink.sv
// ---------------------------------------------------------------------------
// sd_dma_byte_sink
//   Wishbone slave on the SD controller DMA port. Buffers 32-bit sector-read
//   writes in a word FIFO and unpacks them into a byte stream.
//   Ports:
//     wb_clk_i, wb_rst_ni   clock, synchronous active-low reset
//     wb (slave modport)    DMA Wishbone bus; registered ack, dat_o = 0
//     flush_i               discard all buffered data, clear sector count
//     byte_o/byte_valid_o/byte_ready_i   output byte stream (valid/ready)
//     level_o               FIFO word count (word in the unpacker excluded)
//     sector_space_o        room for a full sector in the FIFO
//     block_done_o          pulses with the ack of the last word of a sector
// ---------------------------------------------------------------------------
module sd_dma_byte_sink
  import sd_dma_byte_sink_pkg::*;
#(
  parameter int FIFO_DEPTH   = 256,
  parameter int SECTOR_WORDS = 128,
  parameter int BYTE_SWAP    = 0
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  sd_dma_byte_sink_if.slave           wb,
  input  logic                        flush_i,
  output logic [7:0]                  byte_o,
  output logic                        byte_valid_o,
  input  logic                        byte_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        sector_space_o,
  output logic                        block_done_o
);
  localparam int          LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int          SC_W    = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
  localparam lane_order_e ORDER   = (BYTE_SWAP != 0) ? LANE_LSB_FIRST : LANE_MSB_FIRST;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] SECT_L  = LVL_W'(SECTOR_WORDS);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SECTOR_WORDS - 1);

  // Wishbone slave
  logic            ack_q;
  logic            block_done_q;
  logic [SC_W-1:0] sect_cnt_q;
  logic            wb_req;
  logic            wr_accept;
  logic            rd_accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [LVL_W-1:0] fifo_count;
  fifo_word_t      fifo_wdata;
  fifo_word_t      head;
  logic            unused_adr;

  assign unused_adr = ^wb.dma_wb_adr_i;

  assign wb_req    = wb.dma_wb_cyc_i & wb.dma_wb_stb_i & ~ack_q & ~flush_i;
  // fifo_full is the registered state, so a same-cycle pop never frees a slot
  assign wr_accept = wb_req &  wb.dma_wb_we_i & ~fifo_full;
  assign rd_accept = wb_req & ~wb.dma_wb_we_i;

  // A sel=0000 word carries no bytes: it is acked and counted toward the
  // sector but never stored, so it cannot open a gap in the byte stream.
  assign fifo_push  = wr_accept & (wb.dma_wb_sel_i != 4'b0000);
  assign fifo_wdata = '{sel: wb.dma_wb_sel_i, dat: wb.dma_wb_dat_i};

  assign wb.dma_wb_ack_o = ack_q;
  assign wb.dma_wb_dat_o = '0;
  assign block_done_o    = block_done_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q        <= 1'b0;
      block_done_q <= 1'b0;
      sect_cnt_q   <= '0;
    end else begin
      ack_q        <= wr_accept | rd_accept;
      block_done_q <= wr_accept & (sect_cnt_q == SC_LAST);
      if (flush_i)
        sect_cnt_q <= '0;
      else if (wr_accept)
        sect_cnt_q <= (sect_cnt_q == SC_LAST) ? '0 : sect_cnt_q + SC_W'(1);
    end
  end

  sd_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WORD_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clear (flush_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign level_o        = fifo_count;
  assign sector_space_o = ((DEPTH_L - fifo_count) >= SECT_L);

  // Unpacker: byte_q holds the byte on offer, mask_q the lanes still to come
  unpk_state_e state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  byte_q, byte_d;
  logic        vld_q, vld_d;
  logic        load;
  logic [1:0]  head_lane;
  logic [1:0]  rem_lane;

  assign head_lane = first_lane(head.sel, ORDER);
  assign rem_lane  = first_lane(mask_q, ORDER);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    mask_d   = mask_q;
    byte_d   = byte_q;
    vld_d    = vld_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      UNPK_EMPTY: begin
        if (!fifo_empty) load = 1'b1;
      end
      UNPK_EMIT: begin
        if (byte_ready_i) begin
          if (mask_q != 4'b0000) begin
            byte_d = word_q[{rem_lane, 3'b000} +: 8];
            mask_d = mask_q & ~(4'b0001 << rem_lane);
          end else if (!fifo_empty) begin
            // back-to-back word: reload in the same cycle, no bubble
            load = 1'b1;
          end else begin
            state_d = UNPK_EMPTY;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = UNPK_EMPTY;
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      word_d   = head.dat;
      byte_d   = head.dat[{head_lane, 3'b000} +: 8];
      mask_d   = head.sel & ~(4'b0001 << head_lane);
      vld_d    = 1'b1;
      state_d  = UNPK_EMIT;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || flush_i) begin
      state_q <= UNPK_EMPTY;
      mask_q  <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    word_q <= word_d;
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;

endmodule

// File: tb/tb_sd_dma_byte_sink.sv
// ---------------------------------------------------------------------------
// tb_sd_dma_byte_sink
//   Directed bench for sd_dma_byte_sink (depth 256, sector 128, MSB first).
//   Stimulus pushes expected bytes into a queue; a monitor on the falling
//   edge pops and compares every accepted byte and checks byte_o stays put
//   while valid is stalled.
// ---------------------------------------------------------------------------
module tb_sd_dma_byte_sink;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [8:0] level;
  logic       sector_space;
  logic       block_done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_bytes = 0;
  int done_pulses = 0;
  logic [7:0] exp_q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  sd_dma_byte_sink_if wbif();

  sd_dma_byte_sink #(
    .FIFO_DEPTH   (256),
    .SECTOR_WORDS (128),
    .BYTE_SWAP    (0)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .wb             (wbif),
    .flush_i        (flush),
    .byte_o         (byte_out),
    .byte_valid_o   (byte_valid),
    .byte_ready_i   (byte_ready),
    .level_o        (level),
    .sector_space_o (sector_space),
    .block_done_o   (block_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: inputs change just after posedge, so the falling edge
  // sees exactly what the DUT samples on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && block_done) done_pulses++;
    if (hold_prev) begin
      n_tests++;
      if (!byte_valid || byte_out !== prev_byte) begin
        n_fail++;
        $display("FAIL hold: got valid=%0b byte=0x%0h, required valid=1 byte=0x%0h",
                 byte_valid, byte_out, prev_byte);
      end
    end
    if (rst_n && byte_valid && byte_ready) begin
      n_tests++;
      n_bytes++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream: got unexpected byte 0x%0h, required none", byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_out !== e) begin
          n_fail++;
          $display("FAIL stream: got 0x%0h, required 0x%0h", byte_out, e);
        end
      end
    end
    hold_prev = rst_n && !flush && byte_valid && !byte_ready;
    prev_byte = byte_out;
  end

  task automatic wb_write(input logic [31:0] d, input logic [3:0] s, input bit model,
                          output bit acked, output int waited, output bit bd);
    wbif.dma_wb_adr_i = 32'h0;
    wbif.dma_wb_dat_i = d;
    wbif.dma_wb_sel_i = s;
    wbif.dma_wb_we_i  = 1'b1;
    wbif.dma_wb_cyc_i = 1'b1;
    wbif.dma_wb_stb_i = 1'b1;
    acked = 1'b0;
    waited = 0;
    bd = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (wbif.dma_wb_ack_o) begin
        acked = 1'b1;
        waited = i;
        bd = block_done;
        break;
      end
    end
    wbif.dma_wb_cyc_i = 1'b0;
    wbif.dma_wb_stb_i = 1'b0;
    wbif.dma_wb_we_i  = 1'b0;
    if (!acked) begin
      n_tests++;
      n_fail++;
      $display("FAIL wr_timeout: got no ack for 0x%0h, required ack", d);
    end else if (model) begin
      for (int l = 3; l >= 0; l--)
        if (s[l]) exp_q.push_back(d[8*l +: 8]);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  bit   a, b;
  int   w;
  int   bd_cnt, pulses0, bytes0, acks;
  logic [5:0] vpat;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    byte_ready = 1'b0;
    wbif.dma_wb_adr_i = '0;
    wbif.dma_wb_dat_i = '0;
    wbif.dma_wb_sel_i = '0;
    wbif.dma_wb_we_i  = 1'b0;
    wbif.dma_wb_cyc_i = 1'b0;
    wbif.dma_wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wbif.dma_wb_ack_o}, 0);
    check("rst_valid", {31'b0, byte_valid}, 0);
    check("rst_byte", {24'b0, byte_out}, 0);
    check("rst_level", {23'b0, level}, 0);
    check("rst_space", {31'b0, sector_space}, 1);
    check("rst_done", {31'b0, block_done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single word, MSB-first, ack after one edge, four consecutive bytes
    byte_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    wb_write(32'h11223344, 4'hF, 0, a, w, b);
    check("t1_ack_latency", w, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vpat[i] = byte_valid;
    end
    check("t1_valid_pattern", {27'b0, vpat[4:0]}, 32'h0F);
    check("t1_drained", exp_q.size(), 0);

    // Read: acked next cycle with zero data, no FIFO effect
    wbif.dma_wb_we_i = 1'b0; wbif.dma_wb_cyc_i = 1'b1; wbif.dma_wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("rd_ack", {31'b0, wbif.dma_wb_ack_o}, 1);
    check("rd_dat", wbif.dma_wb_dat_o, 0);
    wbif.dma_wb_cyc_i = 1'b0; wbif.dma_wb_stb_i = 1'b0;
    @(posedge clk); #1;
    check("rd_level", {23'b0, level}, 0);

    // stb without cyc is ignored
    acks = 0;
    wbif.dma_wb_we_i = 1'b1; wbif.dma_wb_stb_i = 1'b1; wbif.dma_wb_dat_i = 32'hCAFEF00D;
    wbif.dma_wb_sel_i = 4'hF;
    repeat (4) begin
      @(posedge clk); #1;
      if (wbif.dma_wb_ack_o) acks++;
    end
    wbif.dma_wb_stb_i = 1'b0; wbif.dma_wb_we_i = 1'b0;
    check("stb_only_acks", acks, 0);
    check("stb_only_level", {23'b0, level}, 0);

    // 2: one sector with ready low; first word sits in the unpacker
    byte_ready = 1'b0;
    do_flush();
    pulses0 = done_pulses;
    bd_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      wb_write(32'h00010203 + 32'h04040404 * i, 4'hF, 1, a, w, b);
      if (b) bd_cnt++;
      if (i == 127) check("t2_done_on_128th", {31'b0, b}, 1);
    end
    check("t2_done_count", bd_cnt, 1);
    @(posedge clk); #1;
    check("t2_done_pulses", done_pulses - pulses0, 1);
    check("t2_level", {23'b0, level}, 127);
    check("t2_space", {31'b0, sector_space}, 1);
    wb_write(32'hA0A0A0A0, 4'hF, 1, a, w, b);
    wb_write(32'hA1A1A1A1, 4'hF, 1, a, w, b);
    check("t2_level_129", {23'b0, level}, 129);
    check("t2_space_129", {31'b0, sector_space}, 0);

    // 3: fill to full, next write stalls until one word is freed
    for (int i = 0; i < 127; i++) wb_write(32'hB0000000 + i, 4'hF, 1, a, w, b);
    check("t3_level_full", {23'b0, level}, 256);
    wbif.dma_wb_dat_i = 32'hF00DF00D; wbif.dma_wb_sel_i = 4'hF;
    wbif.dma_wb_we_i = 1'b1; wbif.dma_wb_cyc_i = 1'b1; wbif.dma_wb_stb_i = 1'b1;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (wbif.dma_wb_ack_o) acks++;
    end
    check("t3_no_ack_full", acks, 0);
    bytes0 = n_bytes;
    byte_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    byte_ready = 1'b0;
    check("t3_one_word_freed", {23'b0, level}, 255);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wbif.dma_wb_ack_o) begin acks++; break; end
    end
    wbif.dma_wb_cyc_i = 1'b0; wbif.dma_wb_stb_i = 1'b0; wbif.dma_wb_we_i = 1'b0;
    check("t3_ack_after_free", acks, 1);
    check("t3_bytes_taken", n_bytes - bytes0, 4);
    check("t3_level_refull", {23'b0, level}, 256);

    // 4: sparse lanes and an empty word, drained with no gaps
    do_flush();
    exp_q.push_back(8'hAA); exp_q.push_back(8'hDD);
    wb_write(32'hAABBCCDD, 4'b1001, 0, a, w, b);
    wb_write(32'hDEADBEEF, 4'b0000, 0, a, w, b);
    check("t4_sel0_acked", {31'b0, a}, 1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    wb_write(32'h01020304, 4'hF, 0, a, w, b);
    byte_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vpat[i] = byte_valid;
    end
    check("t4_no_gaps", {26'b0, vpat}, 32'h1F);
    check("t4_drained", exp_q.size(), 0);

    // 5: ready toggling over 512 bytes
    byte_ready = 1'b0;
    do_flush();
    bytes0 = n_bytes;
    fork
      begin
        for (int i = 0; i < 128; i++) wb_write(32'h9E3779B9 * (i + 1), 4'hF, 1, a, w, b);
      end
      begin
        for (int c = 0; c < 1400; c++) begin
          byte_ready = (c % 2 == 0);
          @(posedge clk); #1;
        end
      end
    join
    byte_ready = 1'b0;
    check("t5_drained", exp_q.size(), 0);
    check("t5_byte_count", n_bytes - bytes0, 512);

    // 6: flush while stalled with 40 words queued
    for (int i = 0; i < 41; i++) wb_write(32'hC0000000 + i, 4'hF, 0, a, w, b);
    check("t6_level_40", {23'b0, level}, 40);
    check("t6_valid_before", {31'b0, byte_valid}, 1);
    do_flush();
    check("t6_valid_after", {31'b0, byte_valid}, 0);
    check("t6_level_after", {23'b0, level}, 0);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    wb_write(32'h55667788, 4'hF, 0, a, w, b);
    byte_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("t6_drained", exp_q.size(), 0);
    byte_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
